// File: rtl/exec_pipeline_if.sv
// exec_pipeline_if: decode-to-writeback bus of the execute pipeline.
interface exec_pipeline_if #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int IMM_W    = 16,
  parameter int SHAMT_W  = 5
);
  localparam int REG_AW = $clog2(NUM_REGS);
  logic               in_valid;
  logic               in_ready;
  logic [REG_AW-1:0]  in_rs;
  logic [REG_AW-1:0]  in_rt;
  logic [REG_AW-1:0]  in_wreg;
  logic               in_reg_write;
  logic               in_alu_src;
  logic [IMM_W-1:0]   in_imm;
  logic [3:0]         in_alu_ctrl;
  logic [SHAMT_W-1:0] in_shamt;
  logic               hold;
  logic               flush;
  logic               out_valid;
  logic [DATA_W-1:0]  out_result;
  logic [REG_AW-1:0]  out_wreg;
  logic               out_zf;
  logic [31:0]        retired_cnt;
  logic [REG_AW-1:0]  dbg_addr;
  logic [DATA_W-1:0]  dbg_data;
  modport master (
    output in_valid, in_rs, in_rt, in_wreg, in_reg_write, in_alu_src, in_imm,
           in_alu_ctrl, in_shamt, hold, flush, dbg_addr,
    input  in_ready, out_valid, out_result, out_wreg, out_zf, retired_cnt, dbg_data
  );
  modport slave (
    input  in_valid, in_rs, in_rt, in_wreg, in_reg_write, in_alu_src, in_imm,
           in_alu_ctrl, in_shamt, hold, flush, dbg_addr,
    output in_ready, out_valid, out_result, out_wreg, out_zf, retired_cnt, dbg_data
  );
endinterface

// File: rtl/exec_pipeline.sv
// exec_pipeline: two-stage execute/writeback core with register file, ALU,
// RAW forwarding, hold/flush and a retire counter.
module exec_pipeline #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int IMM_W    = 16,
  parameter int SHAMT_W  = 5
) (
  input logic clk,
  input logic rst_n,
  exec_pipeline_if.slave bus
);
  localparam int REG_AW = $clog2(NUM_REGS);
  logic [DATA_W-1:0]  rf_q [NUM_REGS];
  logic               idex_v_q, idex_rw_q;
  logic [REG_AW-1:0]  idex_wreg_q;
  logic [DATA_W-1:0]  a_q, b_q;
  logic [3:0]         ctrl_q;
  logic [SHAMT_W-1:0] sh_q;
  logic               wb_v_q, zf_q;
  logic [DATA_W-1:0]  res_q;
  logic [REG_AW-1:0]  wreg_q;
  logic [31:0]        cnt_q;
  logic [DATA_W-1:0]  alu, a_d, b_d, imm_x, rt_val;
  logic               fire, fwd_ok;
  // A flushed ID/EX instruction never writes, so it must not forward either.
  assign fire   = !bus.hold && idex_v_q && !bus.flush;
  assign fwd_ok = idex_v_q && !bus.flush && idex_rw_q && idex_wreg_q != '0;
  assign imm_x  = {{(DATA_W-IMM_W){bus.in_imm[IMM_W-1]}}, bus.in_imm};
  assign a_d    = (fwd_ok && idex_wreg_q == bus.in_rs) ? alu :
                  (bus.in_rs == '0) ? '0 : rf_q[bus.in_rs];
  assign rt_val = (fwd_ok && idex_wreg_q == bus.in_rt) ? alu :
                  (bus.in_rt == '0) ? '0 : rf_q[bus.in_rt];
  assign b_d    = bus.in_alu_src ? imm_x : rt_val;
  always_comb begin
    case (ctrl_q)
      4'b0000: alu = a_q & b_q;
      4'b0001: alu = a_q | b_q;
      4'b0010: alu = a_q + b_q;
      4'b0110: alu = a_q - b_q;
      4'b0111: alu = {{(DATA_W-1){1'b0}}, $signed(a_q) < $signed(b_q)};
      4'b1100: alu = ~(a_q | b_q);
      4'b1000: alu = b_q << sh_q;
      4'b1001: alu = b_q >> sh_q;
      4'b1010: alu = $unsigned($signed(b_q) >>> sh_q);
      default: alu = '0;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idex_v_q <= 1'b0;
      wb_v_q   <= 1'b0;
      res_q    <= '0;
      wreg_q   <= '0;
      zf_q     <= 1'b0;
      cnt_q    <= '0;
      for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
    end else if (!bus.hold) begin
      wb_v_q <= fire;
      if (fire) begin
        res_q  <= alu;
        wreg_q <= idex_wreg_q;
        zf_q   <= alu == '0;
        cnt_q  <= cnt_q + 32'd1;
        if (idex_rw_q && idex_wreg_q != '0) rf_q[idex_wreg_q] <= alu;
      end
      idex_v_q <= bus.in_valid;
      if (bus.in_valid) begin
        a_q         <= a_d;
        b_q         <= b_d;
        ctrl_q      <= bus.in_alu_ctrl;
        sh_q        <= bus.in_shamt;
        idex_wreg_q <= bus.in_wreg;
        idex_rw_q   <= bus.in_reg_write;
      end
    end else if (bus.flush) begin
      idex_v_q <= 1'b0;
    end
  end
  assign bus.in_ready    = !bus.hold;
  assign bus.out_valid   = wb_v_q;
  assign bus.out_result  = res_q;
  assign bus.out_wreg    = wreg_q;
  assign bus.out_zf      = zf_q;
  assign bus.retired_cnt = cnt_q;
  assign bus.dbg_data    = (bus.dbg_addr == '0) ? '0 : rf_q[bus.dbg_addr];
endmodule

// File: tb/tb_exec_pipeline.sv
// tb_exec_pipeline: directed vector table followed by randomized traffic
// checked against a sequential-semantics reference model.
module tb_exec_pipeline;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int fails = 0;
  always #5 clk = ~clk;
  exec_pipeline_if bus ();
  exec_pipeline dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  typedef struct {
    logic        rst_n, hold, flush, v, src;
    logic [4:0]  rs, rt, wd, dbg;
    logic [15:0] imm;
    logic [3:0]  ctrl;
    logic        ev;
    logic [31:0] eres;
    logic [4:0]  ewreg;
    logic [31:0] ecnt, edbg;
  } vec_t;
  vec_t tbl[$];
  function automatic vec_t mk(logic r, logic h, logic f, logic v, logic [4:0] rs, logic [4:0] rt,
                              logic [4:0] wd, logic src, logic [15:0] imm, logic [3:0] ctrl,
                              logic [4:0] dbg, logic ev, logic [31:0] eres, logic [4:0] ewreg,
                              logic [31:0] ecnt, logic [31:0] edbg);
    vec_t x;
    x.rst_n = r; x.hold = h; x.flush = f; x.v = v; x.src = src;
    x.rs = rs; x.rt = rt; x.wd = wd; x.dbg = dbg; x.imm = imm; x.ctrl = ctrl;
    x.ev = ev; x.eres = eres; x.ewreg = ewreg; x.ecnt = ecnt; x.edbg = edbg;
    return x;
  endfunction
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  function automatic logic [31:0] alu_ref(logic [3:0] c, logic [31:0] a, logic [31:0] b, logic [4:0] s);
    case (c)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1100: return ~(a | b);
      4'b1000: return b << s;
      4'b1001: return b >> s;
      4'b1010: return $unsigned($signed(b) >>> s);
      default: return 32'd0;
    endcase
  endfunction
  // Reference model: architectural registers plus the one instruction still in flight.
  logic [31:0] m_rf [32];
  logic        p_valid, p_rw;
  logic [4:0]  p_wreg;
  logic [31:0] p_res;
  logic        m_ov, m_zf;
  logic [31:0] m_res, m_cnt;
  logic [4:0]  m_wreg;
  function automatic logic [31:0] reg_val(logic [4:0] r);
    if (r == 0) return 32'd0;
    if (p_valid && !bus.flush && p_rw && p_wreg == r) return p_res;
    return m_rf[r];
  endfunction
  task automatic model_edge();
    logic [31:0] a, b, nres;
    if (!rst_n) begin
      foreach (m_rf[i]) m_rf[i] = 32'd0;
      p_valid = 0; m_ov = 0; m_zf = 0; m_res = 0; m_cnt = 0; m_wreg = 0;
      return;
    end
    if (bus.hold) begin
      if (bus.flush) p_valid = 0;
      return;
    end
    a = reg_val(bus.in_rs);
    b = bus.in_alu_src ? {{16{bus.in_imm[15]}}, bus.in_imm} : reg_val(bus.in_rt);
    nres = alu_ref(bus.in_alu_ctrl, a, b, bus.in_shamt);
    m_ov = p_valid && !bus.flush;
    if (m_ov) begin
      m_res = p_res; m_wreg = p_wreg; m_zf = (p_res == 0); m_cnt++;
      if (p_rw && p_wreg != 0) m_rf[p_wreg] = p_res;
    end
    p_valid = bus.in_valid;
    if (bus.in_valid) begin
      p_rw = bus.in_reg_write; p_wreg = bus.in_wreg; p_res = nres;
    end
  endtask
  initial begin
    bus.in_valid = 0; bus.in_rs = 0; bus.in_rt = 0; bus.in_wreg = 0; bus.in_reg_write = 0;
    bus.in_alu_src = 0; bus.in_imm = 0; bus.in_alu_ctrl = 0; bus.in_shamt = 0;
    bus.hold = 0; bus.flush = 0; bus.dbg_addr = 0;
    tbl.push_back(mk(0,0,0,0, 0,0,0,0,16'h0,4'h0,    1, 0,32'h0,0,0,32'h0));
    tbl.push_back(mk(1,0,0,1, 0,0,1,1,16'hFFFF,4'h2, 1, 0,32'h0,0,0,32'h0));
    tbl.push_back(mk(1,0,0,1, 0,0,2,1,16'h5,4'h2,    1, 1,32'hFFFFFFFF,1,1,32'hFFFFFFFF));
    tbl.push_back(mk(1,0,0,1, 2,2,3,0,16'h0,4'h2,    2, 1,32'd5,2,2,32'd5));
    tbl.push_back(mk(1,0,0,1, 0,0,0,1,16'h7,4'h2,    3, 1,32'd10,3,3,32'd10));
    tbl.push_back(mk(1,0,0,0, 0,0,0,0,16'h0,4'h0,    0, 1,32'd7,0,4,32'd0));
    tbl.push_back(mk(1,0,0,1, 1,1,4,0,16'h0,4'h6,    1, 0,32'd7,0,4,32'hFFFFFFFF));
    tbl.push_back(mk(1,0,1,1, 0,0,5,1,16'h3,4'h1,    4, 0,32'd7,0,4,32'd0));
    tbl.push_back(mk(1,0,0,0, 0,0,0,0,16'h0,4'h0,    5, 1,32'd3,5,5,32'd3));
    tbl.push_back(mk(1,0,0,1, 5,0,6,1,16'h1,4'h2,    5, 0,32'd3,5,5,32'd3));
    tbl.push_back(mk(1,0,0,1, 6,0,7,1,16'h2,4'h2,    6, 1,32'd4,6,6,32'd4));
    tbl.push_back(mk(1,1,0,1, 0,0,8,1,16'h9,4'h2,    6, 1,32'd4,6,6,32'd4));
    tbl.push_back(mk(1,1,0,1, 0,0,8,1,16'h9,4'h2,    7, 1,32'd4,6,6,32'd0));
    tbl.push_back(mk(1,1,0,1, 0,0,8,1,16'h9,4'h2,    8, 1,32'd4,6,6,32'd0));
    tbl.push_back(mk(1,0,0,0, 0,0,0,0,16'h0,4'h0,    7, 1,32'd6,7,7,32'd6));
    tbl.push_back(mk(1,0,0,1, 0,0,9,1,16'h1,4'h2,    7, 0,32'd6,7,7,32'd6));
    tbl.push_back(mk(1,0,0,1, 0,0,10,1,16'h2,4'h2,   9, 1,32'd1,9,8,32'd1));
    tbl.push_back(mk(0,0,0,1, 0,0,11,1,16'h3,4'h2,   9, 0,32'd0,0,0,32'd0));
    tbl.push_back(mk(1,0,0,1, 0,0,12,1,16'h20,4'h2, 10, 0,32'd0,0,0,32'd0));
    tbl.push_back(mk(1,0,0,0, 0,0,0,0,16'h0,4'h0,   12, 1,32'h20,12,1,32'h20));
    tbl.push_back(mk(1,0,0,0, 0,0,0,0,16'h0,4'h0,   11, 0,32'h20,12,1,32'd0));
    tbl.push_back(mk(1,0,0,1, 0,0,13,1,16'h11,4'h2, 13, 0,32'h20,12,1,32'd0));
    tbl.push_back(mk(1,1,1,1, 0,0,14,1,16'h22,4'h2, 13, 0,32'h20,12,1,32'd0));
    tbl.push_back(mk(1,0,0,0, 0,0,0,0,16'h0,4'h0,   13, 0,32'h20,12,1,32'd0));
    foreach (tbl[k]) begin
      rst_n = tbl[k].rst_n; bus.hold = tbl[k].hold; bus.flush = tbl[k].flush;
      bus.in_valid = tbl[k].v; bus.in_reg_write = tbl[k].v; bus.in_alu_src = tbl[k].src;
      bus.in_rs = tbl[k].rs; bus.in_rt = tbl[k].rt; bus.in_wreg = tbl[k].wd;
      bus.in_imm = tbl[k].imm; bus.in_alu_ctrl = tbl[k].ctrl; bus.in_shamt = 0;
      bus.dbg_addr = tbl[k].dbg;
      @(posedge clk);
      #1;
      chk($sformatf("row%0d in_ready", k), 32'(bus.in_ready), 32'(!tbl[k].hold));
      chk($sformatf("row%0d out_valid", k), 32'(bus.out_valid), 32'(tbl[k].ev));
      chk($sformatf("row%0d out_result", k), bus.out_result, tbl[k].eres);
      chk($sformatf("row%0d out_wreg", k), 32'(bus.out_wreg), 32'(tbl[k].ewreg));
      chk($sformatf("row%0d out_zf", k), 32'(bus.out_zf), 32'd0);
      chk($sformatf("row%0d retired_cnt", k), bus.retired_cnt, tbl[k].ecnt);
      chk($sformatf("row%0d dbg_data", k), bus.dbg_data, tbl[k].edbg);
    end
    for (int n = 0; n < 3000; n++) begin
      rst_n = (n == 0) ? 1'b0 : ($urandom_range(0, 149) != 0);
      bus.hold = ($urandom_range(0, 6) == 0);
      bus.flush = ($urandom_range(0, 9) == 0);
      bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.in_rs = 5'($urandom_range(0, 7));
      bus.in_rt = 5'($urandom_range(0, 7));
      bus.in_wreg = ($urandom_range(0, 15) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      bus.in_reg_write = ($urandom_range(0, 7) != 0);
      bus.in_alu_src = $urandom_range(0, 1) == 1;
      bus.in_imm = 16'($urandom);
      bus.in_alu_ctrl = 4'($urandom_range(0, 15));
      bus.in_shamt = 5'($urandom_range(0, 31));
      bus.dbg_addr = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      @(posedge clk);
      model_edge();
      #1;
      chk("rnd in_ready", 32'(bus.in_ready), 32'(!bus.hold));
      chk("rnd out_valid", 32'(bus.out_valid), 32'(m_ov));
      chk("rnd out_result", bus.out_result, m_res);
      chk("rnd out_wreg", 32'(bus.out_wreg), 32'(m_wreg));
      chk("rnd out_zf", 32'(bus.out_zf), 32'(m_zf));
      chk("rnd retired_cnt", bus.retired_cnt, m_cnt);
      chk("rnd dbg_data", bus.dbg_data, m_rf[bus.dbg_addr]);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/exec_pipeline.md
Name: exec_pipeline

Overview:
- Parametrised two-stage execute/writeback core: owns the architectural register file, the ALU and the pipeline registers between decode and writeback.
- Accepts one decoded instruction per cycle from the decode/control stage.
- Adds features the single-cycle top lacks: sign-extended immediate operand, RAW forwarding, stall (hold), flush, r0 hardwiring, a retire counter and a debug read port.

Parameters:
- DATA_W, 32, datapath and register width
- NUM_REGS, 32, number of architectural registers; REG_AW = clog2(NUM_REGS)
- IMM_W, 16, immediate width; sign-extended to DATA_W
- SHAMT_W, 5, shift-amount width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  decoded instruction present
- in_ready  out  1  equals !hold; transfer occurs when in_valid && in_ready
- in_rs  in  REG_AW  source register A
- in_rt  in  REG_AW  source register B
- in_wreg  in  REG_AW  destination register, already muxed by RegDest
- in_reg_write  in  1  instruction writes in_wreg
- in_alu_src  in  1  0: operand B = reg[rt]; 1: operand B = sext(in_imm)
- in_imm  in  IMM_W  immediate
- in_alu_ctrl  in  4  ALU operation code
- in_shamt  in  SHAMT_W  shift amount
- hold  in  1  freeze the whole pipeline
- flush  in  1  kill the instruction in the ID/EX stage
- out_valid  out  1  result retired this cycle
- out_result  out  DATA_W  retired ALU result
- out_wreg  out  REG_AW  retired destination register
- out_zf  out  1  out_result == 0
- retired_cnt  out  32  count of retired instructions
- dbg_addr  in  REG_AW  debug read address
- dbg_data  out  DATA_W  combinational reg[dbg_addr]; always 0 for address 0

Behaviour:
- Stages:
  - ID/EX register: captured at the accept edge; holds operands, controls and valid.
  - ALU: combinational from ID/EX.
  - EX/WB register: out_* outputs; the register-file write happens on the same edge that loads EX/WB.
- Latency: instruction accepted at edge N retires at edge N+1. out_valid is high for the cycle after N+1. reg[wreg] is updated at N+1.
- ALU codes:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed, result 1/0), 1100 NOR
  - 1000 SLL B by shamt, 1001 SRL, 1010 SRA
  - any other code yields 0
- Arithmetic: ADD/SUB wrap modulo 2^DATA_W; no overflow flag.
- Forwarding: when an instruction is captured while ID/EX valid && reg_write && wreg != 0 && wreg == rs (resp. rt, when alu_src=0), the operand is taken from the current combinational ALU output instead of the RF. No other bypass is needed, since the RF is written at the same edge that EX/WB loads.
- Register 0: reads 0; writes to it are discarded, but the instruction still retires with out_valid and counts in retired_cnt.
- EX/WB loading: loads with valid = ID/EX valid on every non-hold edge; a bubble gives out_valid=0.
- hold=1:
  - in_ready=0; no accept.
  - ID/EX and EX/WB are frozen and there is no RF write.
  - out_* keep their values; out_valid stays as-is but retired_cnt does not increment again.
- flush=1 (not held): ID/EX valid is cleared, so that instruction never writes or retires. A simultaneously presented input is still accepted into ID/EX.
- flush=1 with hold=1: flush wins for ID/EX valid; EX/WB stays frozen.
- retired_cnt: increments by 1 on each non-hold edge that loads EX/WB with valid=1; wraps 0xFFFFFFFF -> 0.
- Reset (rst_n=0 at an edge):
  - Clears ID/EX valid, EX/WB valid, out_result, out_wreg, out_zf, retired_cnt and every register to 0.
  - in-flight instructions are dropped.
  - in_ready = !hold, including during reset.

Test Plan:
- Reset, then ADDI r1 = r0 + sext(0xFFFF) (alu_src=1, ctrl 0010) -> after 2 edges out_result=0xFFFFFFFF, out_wreg=1, reg[1]=0xFFFFFFFF, retired_cnt=1.
- Back-to-back RAW: r2 = r0+5 then r3 = r2+r2 on consecutive cycles -> second out_result=10 via forwarding; dbg reads r3=10.
- Write r0 with 7, then read r0 -> out_valid=1, out_result=7, reg[0] reads 0, retired_cnt increments.
- hold asserted for 3 cycles mid-stream -> in_ready=0, out_* frozen, retired_cnt unchanged, no RF writes; resumes with the correct ordering.
- flush while SUB r4 = r1-r1 is in ID/EX -> r4 unchanged, no out_valid for it, out_zf unchanged; the next instruction retires normally.
- rst_n low while 2 instructions are in flight -> all outputs and registers 0, retired_cnt=0; the first post-reset instruction has latency 2.
